mod_updown_counter: RTL and testbench

Parametrised synchronous up/down counter: the next generation of our 4-bit ripple counter. Programmable width and modulus, direction control, parallel load, wrap or saturate mode, an input prescaler, and a sticky overflow flag. All state changes on the same rising clock edge; there is no ripple between stages. Used as the general-purpose event/tick counter in timer and sequencing logic.

---
 rtl/counter_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 39 +++
 rtl/mod_updown_counter.sv | 87 ++++++++
 tb/tb_mod_updown_counter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
// Direction and mode encodings match the raw `up` and `sat` input levels.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // Ceiling log2; clog2(1) is 0, so callers clamp to a minimum width of 1.
  function automatic int clog2(input longint n);
    int r;
    r = 0;
    while ((64'sd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles down to one `step` pulse every PRESCALE enabled cycles.
// `clr` restarts the division so the next step needs a full PRESCALE enabled cycles.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clr};
    assign step = en;
  end else begin : g_count
    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] pcnt;

    assign step = en && (pcnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pcnt <= '0;
      end else if (clr) begin
        pcnt <= '0;
      end else if (en) begin
        pcnt <= step ? '0 : pcnt + ONE;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with prescaled stepping, parallel load, wrap/saturate
// modes, a one-cycle wrap pulse and a sticky overflow flag.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'sd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
    $error("mod_updown_counter: PRESCALE must be in 1..65536");
  end

  // MODULUS may equal 2**WIDTH, so the top state is held one bit wider.
  localparam logic [WIDTH:0]   MOD_MAX = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP     = MOD_MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             step;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH-1:0] load_clamped;
  logic             limit_hit;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .step(step)
  );

  assign count_ext    = {1'b0, count};
  assign load_ext     = {1'b0, load_val};
  assign load_clamped = (load_ext > MOD_MAX) ? TOP : load_val;
  assign limit_hit    = (up == DIR_UP) ? (count_ext == MOD_MAX) : (count == '0);
  assign at_limit     = limit_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count <= load_clamped;
      end else if (step) begin
        if (!limit_hit) begin
          count <= (up == DIR_UP) ? count + ONE : count - ONE;
        end else if (sat == MODE_WRAP) begin
          count <= (up == DIR_UP) ? '0 : TOP;
          wrap  <= 1'b1;
        end
      end
      // A limit hit on this edge beats a simultaneous clear.
      if (!load && step && limit_hit) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: two instances (PRESCALE 1 and 3, MODULUS 10)
// driven in lockstep and compared against an arithmetic reference model.
module tb_mod_updown_counter;

  typedef struct {
    logic       en;
    logic       up;
    logic       sat;
    logic       load;
    logic [3:0] load_val;
    logic       clr_ovf;
  } stim_t;

  typedef struct {
    int count;
    int pcnt;
    int wrap;
    int ovf;
  } mstate_t;

  typedef struct {
    stim_t s;
    int    exp_count;
    int    exp_wrap;
    int    exp_ovf;
    int    exp_limit;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] count_a, count_b;
  logic       at_limit_a, at_limit_b, wrap_a, wrap_b, ovf_a, ovf_b;

  int checks   = 0;
  int failures = 0;
  int mod_of[2] = '{10, 10};
  int pre_of[2] = '{1, 3};
  mstate_t model[2];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .count(count_a),
    .at_limit(at_limit_a), .wrap(wrap_a), .ovf(ovf_a)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .count(count_b),
    .at_limit(at_limit_b), .wrap(wrap_b), .ovf(ovf_b)
  );

  // Reference behaviour written from the counting rules with integer arithmetic.
  function automatic mstate_t model_next(mstate_t s, int m, int p, stim_t in);
    mstate_t n;
    int      hit;
    int      set;
    n = s;
    n.wrap = 0;
    set = 0;
    if (in.load) begin
      n.count = (int'(in.load_val) > m - 1) ? m - 1 : int'(in.load_val);
      n.pcnt  = 0;
    end else begin
      if (in.en) n.pcnt = (s.pcnt + 1) % p;
      if (in.en && s.pcnt == p - 1) begin
        hit = in.up ? (s.count == m - 1) : (s.count == 0);
        set = hit;
        if (in.sat) begin
          n.count = in.up ? ((s.count + 1 > m - 1) ? m - 1 : s.count + 1)
                          : ((s.count - 1 < 0) ? 0 : s.count - 1);
        end else begin
          n.count = in.up ? (s.count + 1) % m : (s.count + m - 1) % m;
          n.wrap  = hit;
        end
      end
    end
    if (set != 0) n.ovf = 1;
    else if (in.clr_ovf) n.ovf = 0;
    return n;
  endfunction

  function automatic int model_limit(mstate_t s, int m, logic dir_up);
    return dir_up ? int'(s.count == m - 1) : int'(s.count == 0);
  endfunction

  task automatic check_output(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_models(string tag);
    check_output({tag, " a.count"}, int'(count_a), model[0].count);
    check_output({tag, " a.wrap"}, int'(wrap_a), model[0].wrap);
    check_output({tag, " a.ovf"}, int'(ovf_a), model[0].ovf);
    check_output({tag, " a.at_limit"}, int'(at_limit_a), model_limit(model[0], mod_of[0], up));
    check_output({tag, " b.count"}, int'(count_b), model[1].count);
    check_output({tag, " b.wrap"}, int'(wrap_b), model[1].wrap);
    check_output({tag, " b.ovf"}, int'(ovf_b), model[1].ovf);
    check_output({tag, " b.at_limit"}, int'(at_limit_b), model_limit(model[1], mod_of[1], up));
  endtask

  // Drive one cycle of inputs, advance the models on the edge, sample 1 time unit later.
  task automatic apply_stimulus(stim_t s, string tag);
    en = s.en; up = s.up; sat = s.sat; load = s.load;
    load_val = s.load_val; clr_ovf = s.clr_ovf;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model[k] = model_next(model[k], mod_of[k], pre_of[k], s);
    #1;
    check_models(tag);
  endtask

  task automatic do_reset();
    en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) model[k] = '{0, 0, 0, 0};
  endtask

  function automatic stim_t mk(logic e, logic u, logic s, logic l, logic [3:0] v, logic c);
    stim_t r;
    r.en = e; r.up = u; r.sat = s; r.load = l; r.load_val = v; r.clr_ovf = c;
    return r;
  endfunction

  vec_t  vecs[$];
  stim_t st;
  vec_t  v;

  initial begin
    // Directed table against instance a (PRESCALE=1), expectations worked by hand.
    for (int i = 1; i <= 10; i++) begin
      v.s = mk(1, 1, 0, 0, 4'd0, 0);
      v.exp_count = i % 10; v.exp_wrap = (i == 10); v.exp_ovf = (i == 10);
      v.exp_limit = (i == 9);
      vecs.push_back(v);
    end
    vecs.push_back('{mk(1, 0, 1, 1, 4'd2, 1), 2, 0, 0, 0});
    vecs.push_back('{mk(1, 0, 1, 0, 4'd0, 0), 1, 0, 0, 0});
    vecs.push_back('{mk(1, 0, 1, 0, 4'd0, 0), 0, 0, 0, 1});
    vecs.push_back('{mk(1, 0, 1, 0, 4'd0, 0), 0, 0, 1, 1});
    vecs.push_back('{mk(1, 0, 1, 0, 4'd0, 0), 0, 0, 1, 1});
    vecs.push_back('{mk(1, 1, 0, 1, 4'd12, 0), 9, 0, 1, 1});
    vecs.push_back('{mk(1, 1, 0, 0, 4'd0, 1), 0, 1, 1, 0});
    vecs.push_back('{mk(0, 1, 0, 0, 4'd0, 1), 0, 0, 0, 0});

    do_reset();
    #1;
    check_output("reset a.count", int'(count_a), 0);
    check_output("reset a.ovf", int'(ovf_a), 0);
    check_output("reset a.wrap", int'(wrap_a), 0);
    check_output("reset a.at_limit up=1", int'(at_limit_a), 0);
    up = 1'b0;
    #1;
    check_output("reset a.at_limit up=0", int'(at_limit_a), 1);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].s, $sformatf("vec%0d", i));
      check_output($sformatf("vec%0d count", i), int'(count_a), vecs[i].exp_count);
      check_output($sformatf("vec%0d wrap", i), int'(wrap_a), vecs[i].exp_wrap);
      check_output($sformatf("vec%0d ovf", i), int'(ovf_a), vecs[i].exp_ovf);
      check_output($sformatf("vec%0d at_limit", i), int'(at_limit_a), vecs[i].exp_limit);
    end

    // Prescale 3 on instance b: steps on enabled edges 3, 6, 9, then a 2-cycle en gap.
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      apply_stimulus(mk(1, 1, 0, 0, 4'd0, 0), "pre");
      check_output($sformatf("pre edge%0d b.count", e), int'(count_b), e / 3);
    end
    repeat (2) apply_stimulus(mk(0, 1, 0, 0, 4'd0, 0), "gap");
    apply_stimulus(mk(1, 1, 0, 0, 4'd0, 0), "gap");
    check_output("gap delayed b.count", int'(count_b), 3);
    apply_stimulus(mk(1, 1, 0, 0, 4'd0, 0), "gap");
    check_output("gap step b.count", int'(count_b), 4);

    // Load of 12 on a step edge of instance b clamps to 9 and restarts the prescaler.
    repeat (2) apply_stimulus(mk(1, 1, 0, 0, 4'd0, 0), "pre2");
    apply_stimulus(mk(1, 1, 0, 1, 4'd12, 0), "clamp");
    check_output("clamp b.count", int'(count_b), 9);
    repeat (2) apply_stimulus(mk(1, 1, 0, 0, 4'd0, 0), "restart");
    check_output("restart hold b.count", int'(count_b), 9);
    apply_stimulus(mk(1, 1, 0, 0, 4'd0, 0), "restart");
    check_output("restart wrap b.count", int'(count_b), 0);
    check_output("restart wrap b.wrap", int'(wrap_b), 1);

    // Asynchronous reset mid-prescale with count=7, pcnt=1.
    apply_stimulus(mk(0, 1, 0, 1, 4'd7, 0), "pre_rst");
    apply_stimulus(mk(1, 1, 0, 0, 4'd0, 0), "pre_rst");
    check_output("pre_rst b.count", int'(count_b), 7);
    check_output("pre_rst b.ovf", int'(ovf_b), 1);
    #1;
    rst = 1'b1;
    #1;
    check_output("async b.count", int'(count_b), 0);
    check_output("async b.ovf", int'(ovf_b), 0);
    check_output("async a.ovf", int'(ovf_a), 0);
    check_output("async b.wrap", int'(wrap_b), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) model[k] = '{0, 0, 0, 0};
    for (int e = 1; e <= 3; e++) begin
      apply_stimulus(mk(1, 1, 0, 0, 4'd0, 0), "post_rst");
      check_output($sformatf("post_rst edge%0d b.count", e), int'(count_b), (e == 3) ? 1 : 0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      st.en       = ($urandom_range(0, 3) != 0);
      st.up       = $urandom_range(0, 1) != 0;
      st.sat      = ($urandom_range(0, 3) == 0);
      st.load     = ($urandom_range(0, 9) == 0);
      st.load_val = 4'($urandom_range(0, 15));
      st.clr_ovf  = ($urandom_range(0, 7) == 0);
      apply_stimulus(st, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
